// File: rtl/data_memory_mmio.sv
//==============================================================================
// data_memory_mmio : 240-word RAM plus GPIO, timer and TX FIFO on an 8-bit/16-bit bus
// Rev 1.0
//==============================================================================
`default_nettype none

module data_memory_mmio #(
  parameter int         RAM_WORDS   = 240,
  parameter logic [7:0] MMIO_BASE   = 8'hF0,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_addr,
  input  logic        i_write_en,
  inout  wire  [15:0] io_data_bus,
  input  logic [15:0] i_gpio_in,
  output logic [15:0] o_gpio_out,
  output logic [15:0] o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_timer_irq
);

  localparam int         PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [8:0] C_RAM_END = 9'(RAM_WORDS);
  localparam int         AW        = $clog2(RAM_WORDS);

  logic [15:0]   r_ram [0:RAM_WORDS-1];
  logic [15:0]   r_sync [0:SYNC_STAGES-1];
  logic [15:0]   r_gpio_out;
  logic [15:0]   r_tmr_cnt;
  logic [15:0]   r_tmr_cmp;
  logic          r_tmr_en;
  logic          r_irq;
  logic [15:0]   r_fifo [0:FIFO_DEPTH-1];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  logic [15:0] w_wdata;
  logic [15:0] w_rdata;
  logic [15:0] w_stat;
  logic [7:0]  w_off;
  logic        w_wr;
  logic        w_is_ram;
  logic        w_is_mmio;
  logic        w_wr_gpio;
  logic        w_wr_cnt;
  logic        w_wr_ctrl;
  logic        w_wr_cmp;
  logic        w_push;
  logic        w_wr_stat;
  logic        w_pop;
  logic        w_accept;
  logic        w_full;
  logic        w_empty;
  logic        w_match;

  // An X/Z write enable must fall to the read side, so only a clean 1 writes.
  assign w_wr      = (i_write_en == 1'b1);
  assign w_wdata   = io_data_bus;
  assign w_is_ram  = ({1'b0, i_addr} < C_RAM_END);
  assign w_is_mmio = (i_addr >= MMIO_BASE);
  assign w_off     = i_addr - MMIO_BASE;

  assign w_wr_gpio = w_wr && w_is_mmio && (w_off == 8'h0);
  assign w_wr_cnt  = w_wr && w_is_mmio && (w_off == 8'h2);
  assign w_wr_ctrl = w_wr && w_is_mmio && (w_off == 8'h3);
  assign w_wr_cmp  = w_wr && w_is_mmio && (w_off == 8'h4);
  assign w_push    = w_wr && w_is_mmio && (w_off == 8'h5);
  assign w_wr_stat = w_wr && w_is_mmio && (w_off == 8'h6);

  assign w_full   = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_pop    = !w_empty && i_tx_ready;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_match  = (r_tmr_cnt == r_tmr_cmp);

  always_comb begin
    w_stat      = '0;
    w_stat[0]   = w_full;
    w_stat[1]   = w_empty;
    w_stat[4:2] = 3'(r_cnt);
    w_stat[5]   = r_ovf;
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_ram) begin
      w_rdata = r_ram[i_addr[AW-1:0]];
    end else if (w_is_mmio) begin
      case (w_off)
        8'h0:    w_rdata = r_gpio_out;
        8'h1:    w_rdata = r_sync[SYNC_STAGES-1];
        8'h2:    w_rdata = r_tmr_cnt;
        8'h3:    w_rdata = {14'd0, r_irq, r_tmr_en};
        8'h4:    w_rdata = r_tmr_cmp;
        8'h6:    w_rdata = w_stat;
        default: w_rdata = '0;
      endcase
    end
  end

  assign io_data_bus = (rst_n && !w_wr) ? w_rdata : 16'bz;

  // RAM is not reset, but a write is still blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr && w_is_ram) begin
      r_ram[i_addr[AW-1:0]] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_gpio_out <= '0;
    end else begin
      r_sync[0] <= i_gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      if (w_wr_gpio) r_gpio_out <= w_wdata;
    end
  end

  // A software write to the count pre-empts both increment and compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr_cnt <= '0;
      r_tmr_cmp <= '0;
      r_tmr_en  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_cmp)  r_tmr_cmp <= w_wdata;
      if (w_wr_ctrl) r_tmr_en  <= w_wdata[0];
      if (w_wr_cnt) begin
        r_tmr_cnt <= w_wdata;
        if (w_wr_ctrl && w_wdata[1]) r_irq <= 1'b0;
      end else if (r_tmr_en && w_match) begin
        r_tmr_cnt <= '0;
        r_irq     <= 1'b1;
      end else begin
        if (r_tmr_en) r_tmr_cnt <= r_tmr_cnt + 16'd1;
        if (w_wr_ctrl && w_wdata[1]) r_irq <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wp] <= w_wdata;
        r_wp         <= PW'((32'(r_wp) + 1) % FIFO_DEPTH);
      end
      if (w_pop) r_rp <= PW'((32'(r_rp) + 1) % FIFO_DEPTH);
      r_cnt <= r_cnt + CW'(w_accept) - CW'(w_pop);
      if (w_push && !w_accept)         r_ovf <= 1'b1;
      else if (w_wr_stat && w_wdata[5]) r_ovf <= 1'b0;
    end
  end

  assign o_gpio_out  = r_gpio_out;
  assign o_tx_valid  = !w_empty;
  assign o_tx_data   = w_empty ? 16'h0000 : r_fifo[r_rp];
  assign o_timer_irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: RAM, GPIO, timer, TX FIFO and async reset.
`default_nettype none

module tb_data_memory_mmio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic        we = 1'b0;
  logic [15:0] drv = 16'h0000;
  logic [15:0] gpio_in = 16'h0000;
  logic        tx_ready = 1'b0;
  wire  [15:0] data_bus;
  logic [15:0] gpio_out;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        irq;
  logic [15:0] rd;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign data_bus = we ? drv : 16'bz;

  // Pull-ups make an undriven bus read as 0xFFFF.
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  data_memory_mmio dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_addr     (addr),
    .i_write_en (we),
    .io_data_bus(data_bus),
    .i_gpio_in  (gpio_in),
    .o_gpio_out (gpio_out),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_timer_irq(irq)
  );

  // Called with clk low; the write commits on the following rising edge.
  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    addr = a; drv = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [15:0] d);
    we = 1'b0; addr = a;
    #1;
    d = data_bus;
  endtask

  task automatic test_reset();
    #1;
    total++; if (gpio_out !== 16'h0) begin bad++; $display("FAIL rst_gpio got=%h want=0000", gpio_out); end
    total++; if (tx_valid !== 1'b0 || tx_data !== 16'h0) begin bad++; $display("FAIL rst_tx got=%b/%h want=0/0000", tx_valid, tx_data); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
    do_read(8'hF0, rd);
    total++; if (rd !== 16'hFFFF) begin bad++; $display("FAIL rst_busz got=%h want=FFFF(undriven)", rd); end
    @(negedge clk); rst_n = 1'b1;
    do_read(8'hF6, rd);
    total++; if (rd !== 16'h0002) begin bad++; $display("FAIL rst_stat got=%h want=0002", rd); end
    do_read(8'hF2, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rst_cnt got=%h want=0000", rd); end
  endtask

  task automatic test_ram();
    do_write(8'h05, 16'h1234);
    do_read(8'h05, rd);
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL ram05 got=%h want=1234", rd); end
    do_write(8'hEF, 16'hBEEF);
    do_read(8'hEF, rd);
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL ramEF got=%h want=BEEF", rd); end
    do_write(8'hF8, 16'h5555);
    do_read(8'hF8, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL unmapF8 got=%h want=0000", rd); end
    do_read(8'hF5, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL txdata_rd got=%h want=0000", rd); end
  endtask

  task automatic test_gpio();
    do_write(8'hF0, 16'hA5A5);
    total++; if (gpio_out !== 16'hA5A5) begin bad++; $display("FAIL gpio_out got=%h want=A5A5", gpio_out); end
    do_read(8'hF0, rd);
    total++; if (rd !== 16'hA5A5) begin bad++; $display("FAIL gpio_rd got=%h want=A5A5", rd); end
    gpio_in = 16'h00FF;
    do_read(8'hF1, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL gpio_in0 got=%h want=0000", rd); end
    @(negedge clk);
    do_read(8'hF1, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL gpio_in1 got=%h want=0000", rd); end
    @(negedge clk);
    do_read(8'hF1, rd);
    total++; if (rd !== 16'h00FF) begin bad++; $display("FAIL gpio_in2 got=%h want=00FF", rd); end
  endtask

  task automatic test_timer();
    logic [15:0] exp_cnt [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    logic        exp_irq [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_write(8'hF4, 16'd3);
    do_write(8'hF3, 16'd1);
    for (int i = 0; i < 5; i++) begin
      do_read(8'hF2, rd);
      total++; if (rd !== exp_cnt[i] || irq !== exp_irq[i]) begin
        bad++; $display("FAIL tmr_step%0d got=%h/%b want=%h/%b", i, rd, irq, exp_cnt[i], exp_irq[i]);
      end
      if (i < 4) @(negedge clk);
    end
    do_read(8'hF3, rd);
    total++; if (rd !== 16'h0003) begin bad++; $display("FAIL tmr_ctrl got=%h want=0003", rd); end
    do_write(8'hF3, 16'h0002);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL tmr_clr got=%b want=0", irq); end
    do_write(8'hF2, 16'hFFFF);
    do_write(8'hF4, 16'd5);
    do_write(8'hF3, 16'd1);
    do_read(8'hF2, rd);
    total++; if (rd !== 16'hFFFF) begin bad++; $display("FAIL tmr_hold got=%h want=FFFF", rd); end
    @(negedge clk);
    do_read(8'hF2, rd);
    total++; if (rd !== 16'h0000 || irq !== 1'b0) begin bad++; $display("FAIL tmr_wrap got=%h/%b want=0000/0", rd, irq); end
    do_write(8'hF3, 16'h0000);
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) do_write(8'hF5, 16'(i));
    do_read(8'hF6, rd);
    total++; if (rd !== 16'h0031) begin bad++; $display("FAIL fifo_full got=%h want=0031", rd); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== 16'(i)) begin
        bad++; $display("FAIL drain%0d got=%b/%h want=1/%h", i, tx_valid, tx_data, 16'(i));
      end
      @(negedge clk);
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL drain_end got=%b want=0", tx_valid); end
    do_read(8'hF6, rd);
    total++; if (rd !== 16'h0022) begin bad++; $display("FAIL fifo_empty got=%h want=0022", rd); end
    do_write(8'hF6, 16'h0020);
    do_read(8'hF6, rd);
    total++; if (rd !== 16'h0002) begin bad++; $display("FAIL ovf_clr got=%h want=0002", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [4] = '{16'd11, 16'd12, 16'd13, 16'd9};
    tx_ready = 1'b0;
    for (int i = 10; i <= 13; i++) do_write(8'hF5, 16'(i));
    tx_ready = 1'b1;
    do_write(8'hF5, 16'd9);
    tx_ready = 1'b0;
    do_read(8'hF6, rd);
    total++; if (rd !== 16'h0011) begin bad++; $display("FAIL pushpop_stat got=%h want=0011", rd); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== exp_d[i]) begin
        bad++; $display("FAIL pp_drain%0d got=%b/%h want=1/%h", i, tx_valid, tx_data, exp_d[i]);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL pp_end got=%b want=0", tx_valid); end
  endtask

  task automatic test_async_reset();
    do_write(8'hF4, 16'd1);
    do_write(8'hF2, 16'd0);
    do_write(8'hF3, 16'd1);
    @(negedge clk);
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_irq got=%b want=1", irq); end
    do_write(8'hF5, 16'd7);
    do_write(8'hF5, 16'd8);
    tx_ready = 1'b1;
    addr = 8'hF0; drv = 16'h1111; we = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++; if (gpio_out !== 16'h0 || tx_valid !== 1'b0 || irq !== 1'b0) begin
      bad++; $display("FAIL async_rst got=%h/%b/%b want=0000/0/0", gpio_out, tx_valid, irq);
    end
    we = 1'b0; addr = 8'h05;
    #1;
    total++; if (data_bus !== 16'hFFFF) begin bad++; $display("FAIL async_busz got=%h want=FFFF(undriven)", data_bus); end
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b0;
    total++; if (gpio_out !== 16'h0) begin bad++; $display("FAIL wr_abort got=%h want=0000", gpio_out); end
    do_read(8'h05, rd);
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL ram_keep05 got=%h want=1234", rd); end
    do_read(8'hEF, rd);
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL ram_keepEF got=%h want=BEEF", rd); end
    do_read(8'hF6, rd);
    total++; if (rd !== 16'h0002) begin bad++; $display("FAIL post_stat got=%h want=0002", rd); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_fifo_overflow();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
